dpe_fcr_ctrl: RTL

//  Flow-control (FCR) quiesce controller at the DPE ingress, upstream of dpe_wg_disassembler.
//  On a CPU request it closes the ingress at a packet boundary and waits until every downstream

---
 rtl/dpe_pkg.sv | 13 +
 rtl/dpe_if.sv | 24 ++
 rtl/dpe_fcr_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/dpe_pkg.sv
// Shared types for the DPE ingress flow-control quiesce logic.
package dpe_pkg;

   typedef enum logic [1:0] {
      RUN,
      DRAIN,
      WAIT_IDLE,
      HALTED
   } fcr_state_t;

   localparam int FCR_SETTLE_DEF = 2;

endpackage

// File: rtl/dpe_if.sv
// AXI-stream style bundle used on the DPE ingress path.
interface dpe_if #(
   parameter int DATA_W = 64,
   parameter int USER_W = 1
);

   logic                  tvalid;
   logic                  tready;
   logic                  tlast;
   logic [DATA_W-1:0]     tdata;
   logic [DATA_W/8-1:0]   tkeep;
   logic [USER_W-1:0]     tuser;

   modport s_axis (
      input  tvalid, tdata, tkeep, tlast, tuser,
      output tready
   );

   modport m_axis (
      output tvalid, tdata, tkeep, tlast, tuser,
      input  tready
   );

endinterface

// File: rtl/dpe_fcr_ctrl.sv
// Ingress quiesce controller: closes the stream at a packet boundary,
// waits for downstream idle, then grants the CPU a config window.
module dpe_fcr_ctrl
   import dpe_pkg::*;
#(
   parameter int NUM_STAGES    = 4,
   parameter int SETTLE_CYCLES = FCR_SETTLE_DEF,
   parameter int TIMEOUT_W     = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_fcr_req,
   output logic                  cpu_fcr_ack,
   output logic                  cpu_fcr_timeout,
   input  logic [TIMEOUT_W-1:0]  timeout_cycles,
   input  logic [NUM_STAGES-1:0] stage_idle,
   dpe_if.s_axis                 inp,
   dpe_if.m_axis                 outp
);

   localparam int SW = $clog2(SETTLE_CYCLES + 1);

   fcr_state_t           state;
   fcr_state_t           state_nxt;
   logic                 in_pkt;
   logic                 open;
   logic                 beat;
   logic                 all_idle;
   logic                 tmo_hit;
   logic [SW-1:0]        settle_cnt;
   logic [SW-1:0]        settle_nxt;
   logic [TIMEOUT_W-1:0] tmo_cnt;

   assign all_idle = &stage_idle;
   assign open     = (state == RUN) | in_pkt;

   assign outp.tvalid = inp.tvalid & open;
   assign outp.tdata  = inp.tdata;
   assign outp.tkeep  = inp.tkeep;
   assign outp.tlast  = inp.tlast;
   assign outp.tuser  = inp.tuser;
   assign inp.tready  = outp.tready & open;

   assign beat    = inp.tvalid & inp.tready;
   assign tmo_hit = (timeout_cycles != '0) &&
                    (tmo_cnt == timeout_cycles);

   always_comb begin
      state_nxt  = state;
      settle_nxt = '0;
      unique case (state)
         RUN: begin
            if (cpu_fcr_req) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (!cpu_fcr_req)  state_nxt = RUN;
            else if (!in_pkt)  state_nxt = WAIT_IDLE;
         end
         WAIT_IDLE: begin
            if (!cpu_fcr_req) begin
               state_nxt = RUN;
            end else if (all_idle) begin
               if (settle_cnt == SW'(SETTLE_CYCLES - 1))
                  state_nxt = HALTED;
               else
                  settle_nxt = settle_cnt + 1'b1;
            end
         end
         HALTED: begin
            if (!cpu_fcr_req) state_nxt = RUN;
         end
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= RUN;
         in_pkt          <= 1'b0;
         settle_cnt      <= '0;
         tmo_cnt         <= '0;
         cpu_fcr_ack     <= 1'b0;
         cpu_fcr_timeout <= 1'b0;
      end else begin
         state       <= state_nxt;
         settle_cnt  <= settle_nxt;
         cpu_fcr_ack <= (state_nxt == HALTED);
         if (beat) in_pkt <= ~inp.tlast;
         // DRAIN is only entered from RUN, so clearing here covers entry
         if (state == RUN) begin
            tmo_cnt <= '0;
         end else if (state == DRAIN || state == WAIT_IDLE) begin
            if (tmo_hit) cpu_fcr_timeout <= 1'b1;
            else         tmo_cnt <= tmo_cnt + 1'b1;
         end
         if (!cpu_fcr_req) cpu_fcr_timeout <= 1'b0;
      end
   end

endmodule
